// File: rtl/rob_multiport.sv
// Reorder buffer: in-order allocate and retire, out-of-order writeback on WB_N
// channels, and a one-cycle flush when a retiring branch/jump was mispredicted.
module rob_multiport #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int WB_N   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  output logic [IDX_W-1:0]       alloc_id,
  input  logic [1:0]             alloc_kind,
  input  logic [ADDR_W-1:0]      alloc_pc,
  input  logic [ADDR_W-1:0]      alloc_pred_pc,
  input  logic [4:0]             alloc_rd,
  input  logic [WB_N-1:0]        wb_valid,
  input  logic [WB_N*IDX_W-1:0]  wb_id,
  input  logic [WB_N*DATA_W-1:0] wb_value,
  input  logic [WB_N*ADDR_W-1:0] wb_addr,
  output logic                   commit_valid,
  output logic [IDX_W-1:0]       commit_id,
  output logic [1:0]             commit_kind,
  output logic [4:0]             commit_rd,
  output logic [ADDR_W-1:0]      commit_pc,
  output logic [DATA_W-1:0]      commit_value,
  output logic [ADDR_W-1:0]      commit_addr,
  output logic                   flush_valid,
  output logic [ADDR_W-1:0]      flush_pc,
  output logic [IDX_W:0]         count
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0]  head, tail;
  logic [DEPTH-1:0]  ready;
  logic [1:0]        kind_mem  [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [ADDR_W-1:0] pred_mem  [DEPTH];
  logic [4:0]        rd_mem    [DEPTH];
  logic [DATA_W-1:0] value_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];

  logic [WB_N-1:0] wb_live;
  logic            alloc_fire, commit_fire, mispredict;

  assign alloc_ready = (count != FULL);
  assign alloc_id    = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = (count != '0) && ready[head];
  assign mispredict  = commit_fire && kind_mem[head][1] &&
                       (addr_mem[head] != pred_mem[head]);

  // An id is live when its wrapped distance from head is below the occupancy.
  always_comb begin
    wb_live = '0;
    for (int k = 0; k < WB_N; k++)
      wb_live[k] = wb_valid[k] &&
                   ({1'b0, wb_id[k*IDX_W +: IDX_W] - head} < count);
  end

  // NOTE: payload arrays are not reset; the ready bits and occupancy alone decide what is live.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !mispredict) begin
      if (alloc_fire) begin
        kind_mem[tail] <= alloc_kind;
        pc_mem[tail]   <= alloc_pc;
        pred_mem[tail] <= alloc_pred_pc;
        rd_mem[tail]   <= alloc_rd;
      end
      // Later channels are written last, so the highest k wins a collision.
      for (int k = 0; k < WB_N; k++) begin
        if (wb_live[k]) begin
          value_mem[wb_id[k*IDX_W +: IDX_W]] <= wb_value[k*DATA_W +: DATA_W];
          addr_mem[wb_id[k*IDX_W +: IDX_W]]  <= wb_addr[k*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ready        <= '0;
      commit_valid <= 1'b0;
      commit_id    <= '0;
      commit_kind  <= '0;
      commit_rd    <= '0;
      commit_pc    <= '0;
      commit_value <= '0;
      commit_addr  <= '0;
      flush_valid  <= 1'b0;
      flush_pc     <= '0;
    end else if (!rdy) begin
      commit_valid <= 1'b0;
      flush_valid  <= 1'b0;
    end else begin
      commit_valid <= commit_fire;
      flush_valid  <= mispredict;
      if (commit_fire) begin
        commit_id    <= head;
        commit_kind  <= kind_mem[head];
        commit_rd    <= rd_mem[head];
        commit_pc    <= pc_mem[head];
        commit_value <= value_mem[head];
        commit_addr  <= addr_mem[head];
      end
      if (mispredict) begin
        flush_pc <= addr_mem[head];
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        ready    <= '0;
      end else begin
        if (alloc_fire) begin
          ready[tail] <= 1'b0;
          tail        <= tail + 1'b1;
        end
        for (int k = 0; k < WB_N; k++)
          if (wb_live[k]) ready[wb_id[k*IDX_W +: IDX_W]] <= 1'b1;
        if (commit_fire) head <= head + 1'b1;
        count <= count + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, commit_fire};
      end
    end
  end

endmodule

// File: doc/rob_multiport.md
# rob_multiport

Parametrised reorder buffer for the out-of-order RV32I core. It sits between the decoder/issue stage and the register file, store path and predictor. It allocates entries in program order and accepts out-of-order results on `WB_N` writeback channels. It retires one entry per cycle in order and raises a single-cycle flush on a control-flow mispredict. It supersedes the fixed 16-entry, two-source ROB, adding a configurable depth, N writeback channels, an explicit allocate handshake and an occupancy output.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `IDX_W`, 4, entry-id width; equals log2(`DEPTH`)
- `DATA_W`, 32, result data width
- `ADDR_W`, 32, PC and address width
- `WB_N`, 2, number of writeback channels
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `rdy`  in  1  global enable; when low, no state changes
- `alloc_valid`  in  1  decoder requests an entry
- `alloc_ready`  out  1  combinational; `count != DEPTH`
- `alloc_id`  out  `IDX_W`  combinational; id the next allocation receives (the tail)
- `alloc_kind`  in  2  0 = reg-write, 1 = store, 2 = branch, 3 = jump
- `alloc_pc`, `alloc_pred_pc`  in  `ADDR_W`  instruction PC; predicted next PC
- `alloc_rd`  in  5  destination register
- `wb_valid`  in  `WB_N`  one bit per channel
- `wb_id`  in  `WB_N*IDX_W`  packed; channel k occupies bits [k*IDX_W +: IDX_W]
- `wb_value`  in  `WB_N*DATA_W`  packed result or store data
- `wb_addr`  in  `WB_N*ADDR_W`  packed; resolved next PC (branch/jump) or store address
- `commit_valid`  out  1  registered one-cycle retire pulse
- `commit_id`  out  `IDX_W`  retired entry id
- `commit_kind`  out  2  retired entry kind
- `commit_rd`  out  5  retired destination register
- `commit_pc`  out  `ADDR_W`  retired instruction PC
- `commit_value`  out  `DATA_W`  retired result or store data
- `commit_addr`  out  `ADDR_W`  retired resolved PC or store address
- `flush_valid`  out  1  registered one-cycle mispredict pulse
- `flush_pc`  out  `ADDR_W`  redirect PC
- `count`  out  `IDX_W+1`  registered occupancy

## Operation
- Storage is a circular buffer with registered `head`, `tail` and `count`. Each entry holds a ready bit plus kind, pc, pred_pc, rd, value and addr.
- Pointer arithmetic wraps modulo `DEPTH` by natural `IDX_W` overflow.
- **Allocate:** fires when `alloc_valid & alloc_ready`. The entry at `tail` is written with ready = 0, then `tail` increments.
  - `alloc_ready` does not account for a commit in the same cycle. A full buffer refuses allocation even while retiring.
- **Writeback:** for each k with `wb_valid[k]`, the entry `wb_id[k]` gets ready = 1, value and addr.
  - If two channels target the same id, the higher k wins.
  - A writeback to an id outside the live window [head, head+count) is ignored.
- **Commit:** happens when `count > 0` and ready[head] is set, using the registered ready bit.
  - `commit_*` is loaded from the head entry and `commit_valid` is set to 1.
  - `head` increments.
- `count` next value = count + alloc fire − commit, so a simultaneous allocate and commit leaves `count` unchanged.
- **Mispredict:** a committing entry of kind 2 or 3 with addr ≠ pred_pc.
  - The entry still commits, with `commit_valid` = 1.
  - `flush_valid` = 1 and `flush_pc` = that entry's addr.
  - On the same edge `head`, `tail` and `count` reset to 0 and all ready bits clear.
  - Any allocation or writeback presented in that cycle is discarded.
- **Stall:** when `rdy` = 0, all state holds and `commit_valid` and `flush_valid` are driven to 0, so no pulse is duplicated.

## Timing
- **Reset values:** `head`, `tail` and `count` are 0 and all ready bits are 0. `commit_valid` and `flush_valid` are 0. All other `commit_*` outputs and `flush_pc` are 0.
- `rst` overrides `rdy`. Reset mid-operation discards every entry with no flush pulse.
- **Latency:** allocate at edge A, writeback at edge W > A, earliest commit pulse after edge W+1.
- A writeback to the head entry cannot retire in the same cycle.
- **Throughput:** at most 1 commit, 1 allocate and `WB_N` writebacks per cycle.
- `alloc_id` is valid in the cycle `alloc_valid` is presented. Downstream stations latch it on the same edge.
- The cycle after a flush, `alloc_ready` = 1 and `alloc_id` = 0.

## Test plan
- **Fill/wrap:** allocate 16 entries (DEPTH = 16) with no writebacks, then `alloc_ready` = 0 and `count` = 16. Write back id 0, see commit id 0 two edges later. Allocate again, the new entry gets id 0 (wrap) and `count` = 16.
- **Out-of-order completion:** allocate ids 0–2 (reg-write, rd = 5, 6, 7). Write back id 2, then 1, then 0 with values 0x22, 0x11, 0x00. Commits occur in order 0, 1, 2 on consecutive cycles with the matching values.
- **Same-id collision:** in one cycle, channels 0 and 1 both write id 3 with values 0xAA and 0xBB. Commit value = 0xBB.
- **Mispredict:** branch at pc 0x100 with pred_pc 0x104 resolves to addr 0x200, with younger entries live. Expect `commit_valid`, `flush_valid`, `flush_pc` = 0x200, then `count` = 0 and `alloc_id` = 0. An allocation presented in the flush cycle is dropped.
- **Correct prediction:** jump with pred_pc = addr = 0x40 commits with `flush_valid` = 0.
- **Stall/reset:** holding `rdy` = 0 for 3 cycles with a ready head gives no commit pulse. Raising `rdy` gives exactly one commit. Asserting `rst` mid-stream gives `count` = 0, all outputs 0, and no flush pulse.
